// File: rtl/h2f_axi_regbank_if.sv
// AXI3 signal bundle between the HPS h2f master bridge and the register bank.
interface h2f_axi_regbank_if #(
  parameter int ADDR_W = 30,
  parameter int ID_W   = 12
);
  // write address channel
  logic [ID_W-1:0]   s_awid;
  logic [ADDR_W-1:0] s_awaddr;
  logic [3:0]        s_awlen;
  logic [2:0]        s_awsize;
  logic [1:0]        s_awburst;
  logic [1:0]        s_awlock;
  logic [3:0]        s_awcache;
  logic [2:0]        s_awprot;
  logic              s_awvalid;
  logic              s_awready;
  // write data channel
  logic [ID_W-1:0]   s_wid;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wlast;
  logic              s_wvalid;
  logic              s_wready;
  // write response channel
  logic [ID_W-1:0]   s_bid;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  // read address channel
  logic [ID_W-1:0]   s_arid;
  logic [ADDR_W-1:0] s_araddr;
  logic [3:0]        s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic [1:0]        s_arlock;
  logic [3:0]        s_arcache;
  logic [2:0]        s_arprot;
  logic              s_arvalid;
  logic              s_arready;
  // read data channel
  logic [ID_W-1:0]   s_rid;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              s_rvalid;
  logic              s_rready;

  modport slave (
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awvalid,
    output s_awready,
    input  s_wid, s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  s_rready
  );

  modport master (
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awvalid,
    input  s_awready,
    output s_wid, s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output s_rready
  );
endinterface

// File: rtl/h2f_axi_regbank.sv
// AXI3 slave register bank on the HPS h2f bridge: one transaction at a time,
// reads and writes arbitrated fairly, FIXED/INCR/WRAP bursts, byte strobes.
//
// state | meaning
// IDLE  | waiting for AW or AR; ready asserted for the granted channel only
// WDATA | accepting len+1 write beats, one per wvalid
// WRESP | presenting bvalid/bid/bresp until bready
// RDATA | presenting registered read beats until the rlast beat is taken
module h2f_axi_regbank #(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 30,
  parameter int ID_W   = 12
) (
  input  logic                 bus_clock_clk,
  input  logic                 bus_reset_reset_n,
  h2f_axi_regbank_if.slave     s,
  output logic [NREGS*32-1:0]  reg_q,
  output logic [NREGS-1:0]     reg_wr_pulse
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [IDX_W-1:0] NREGS_I = IDX_W'(NREGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t            state_q, state_d;
  logic              prio_rd_q;
  logic [31:0]       regs [NREGS];
  logic [NREGS-1:0]  wr_pulse_q;

  logic [ID_W-1:0]   aw_id_q;
  logic [IDX_W-1:0]  w_idx_q;
  logic [3:0]        w_len_q, w_beat_q;
  logic [1:0]        w_burst_q;
  logic              w_bad_q, w_err_q;

  logic [ID_W-1:0]   ar_id_q;
  logic [IDX_W-1:0]  r_idx_q;
  logic [3:0]        r_len_q, r_beat_q;
  logic [1:0]        r_burst_q;
  logic              r_bad_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;

  logic aw_ready, ar_ready, w_ready, b_valid, r_valid;
  logic grant_r, aw_hs, ar_hs, w_hs, r_hs, b_hs;
  logic w_last_beat, w_in_range, w_beat_err, w_do_write;
  logic [SEL_W-1:0]  w_sel;
  logic [IDX_W-1:0]  r_idx_next, rd_idx;
  logic              rd_bad, rd_ok;
  logic [31:0]       rd_word;

  // size, lock, cache, prot and the byte offset carry no meaning here
  logic unused_fields;
  assign unused_fields = ^{s.s_awsize, s.s_awlock, s.s_awcache, s.s_awprot, s.s_awaddr[1:0],
                           s.s_arsize, s.s_arlock, s.s_arcache, s.s_arprot, s.s_araddr[1:0]};

  // Reserved burst type, or a WRAP whose length is not a power of two, poisons every beat.
  function automatic logic burst_illegal(input logic [1:0] burst, input logic [3:0] len);
    logic len_ok;
    len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    burst_illegal = (burst == 2'b11) || ((burst == 2'b10) && !len_ok);
  endfunction

  // WRAP keeps the upper index bits and rolls the low bits inside a len+1 block.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [1:0] burst,
                                                input logic [3:0] len);
    logic [IDX_W-1:0] mask, inc;
    mask = IDX_W'(len);
    inc  = idx + IDX_W'(1);
    case (burst)
      2'b01:   next_idx = inc;
      2'b10:   next_idx = (idx & ~mask) | (inc & mask);
      default: next_idx = idx;
    endcase
  endfunction

  // Arbitration: read only wins a contested grant when it holds priority.
  assign grant_r = s.s_arvalid & (~s.s_awvalid | prio_rd_q);

  assign aw_hs = aw_ready & s.s_awvalid;
  assign ar_hs = ar_ready & s.s_arvalid;
  assign w_hs  = w_ready  & s.s_wvalid;
  assign r_hs  = r_valid  & s.s_rready;
  assign b_hs  = b_valid  & s.s_bready;

  assign w_last_beat = (w_beat_q == w_len_q);
  assign w_in_range  = (w_idx_q < NREGS_I);
  assign w_sel       = w_idx_q[SEL_W-1:0];
  assign w_beat_err  = w_bad_q | ~w_in_range | (s.s_wid != aw_id_q) | (s.s_wlast != w_last_beat);
  assign w_do_write  = w_hs & ~w_bad_q & w_in_range;

  // Read mux serves the first beat straight from AR, later beats from the burst walk.
  assign r_idx_next = next_idx(r_idx_q, r_burst_q, r_len_q);
  assign rd_idx     = (state_q == IDLE) ? s.s_araddr[ADDR_W-1:2] : r_idx_next;
  assign rd_bad     = (state_q == IDLE) ? burst_illegal(s.s_arburst, s.s_arlen) : r_bad_q;
  assign rd_ok      = ~rd_bad & (rd_idx < NREGS_I);
  assign rd_word    = rd_ok ? regs[rd_idx[SEL_W-1:0]] : 32'd0;

  // State register
  always_ff @(posedge bus_clock_clk or negedge bus_reset_reset_n) begin
    if (!bus_reset_reset_n) state_q <= IDLE;
    else                    state_q <= state_d;
  end

  // Next-state and channel handshake decode; ready is held low while in reset
  always_comb begin
    state_d  = state_q;
    aw_ready = 1'b0;
    ar_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    r_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        aw_ready = bus_reset_reset_n & ~grant_r;
        ar_ready = bus_reset_reset_n & grant_r;
        if (aw_ready && s.s_awvalid)      state_d = WDATA;
        else if (ar_ready && s.s_arvalid) state_d = RDATA;
      end
      WDATA: begin
        w_ready = 1'b1;
        if (s.s_wvalid && w_last_beat) state_d = WRESP;
      end
      WRESP: begin
        b_valid = 1'b1;
        if (s.s_bready) state_d = IDLE;
      end
      RDATA: begin
        r_valid = 1'b1;
        if (s.s_rready && rlast_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Priority flips only when a contested grant is resolved
  always_ff @(posedge bus_clock_clk or negedge bus_reset_reset_n) begin
    if (!bus_reset_reset_n) begin
      prio_rd_q <= 1'b0;
    end else if (aw_hs && s.s_arvalid) begin
      prio_rd_q <= 1'b1;
    end else if (ar_hs && s.s_awvalid) begin
      prio_rd_q <= 1'b0;
    end
  end

  // Write burst tracking: latch AW, walk the index and accumulate beat errors
  always_ff @(posedge bus_clock_clk or negedge bus_reset_reset_n) begin
    if (!bus_reset_reset_n) begin
      aw_id_q   <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_burst_q <= '0;
      w_bad_q   <= 1'b0;
      w_err_q   <= 1'b0;
    end else if (aw_hs) begin
      aw_id_q   <= s.s_awid;
      w_idx_q   <= s.s_awaddr[ADDR_W-1:2];
      w_len_q   <= s.s_awlen;
      w_beat_q  <= '0;
      w_burst_q <= s.s_awburst;
      w_bad_q   <= burst_illegal(s.s_awburst, s.s_awlen);
      w_err_q   <= 1'b0;
    end else if (w_hs) begin
      w_idx_q  <= next_idx(w_idx_q, w_burst_q, w_len_q);
      w_beat_q <= w_beat_q + 4'd1;
      if (w_beat_err) w_err_q <= 1'b1;
    end
  end

  // Register array with byte-lane writes and a single-cycle write pulse
  always_ff @(posedge bus_clock_clk or negedge bus_reset_reset_n) begin
    if (!bus_reset_reset_n) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (w_do_write) begin
        for (int b = 0; b < 4; b++) begin
          if (s.s_wstrb[b]) regs[w_sel][8*b +: 8] <= s.s_wdata[8*b +: 8];
        end
        wr_pulse_q[w_sel] <= 1'b1;
      end
    end
  end

  // Read burst: registered beat data loaded on AR and on each non-final R handshake
  always_ff @(posedge bus_clock_clk or negedge bus_reset_reset_n) begin
    if (!bus_reset_reset_n) begin
      ar_id_q   <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= '0;
      r_bad_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else if (ar_hs) begin
      ar_id_q   <= s.s_arid;
      r_idx_q   <= rd_idx;
      r_len_q   <= s.s_arlen;
      r_beat_q  <= '0;
      r_burst_q <= s.s_arburst;
      r_bad_q   <= rd_bad;
      rdata_q   <= rd_word;
      rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      rlast_q   <= (s.s_arlen == 4'd0);
    end else if (r_hs && !rlast_q) begin
      r_idx_q  <= rd_idx;
      r_beat_q <= r_beat_q + 4'd1;
      rdata_q  <= rd_word;
      rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      rlast_q  <= ((r_beat_q + 4'd1) == r_len_q);
    end
  end

  // Flatten the array for user logic
  always_comb begin
    reg_q = '0;
    for (int k = 0; k < NREGS; k++) reg_q[32*k +: 32] = regs[k];
  end

  assign reg_wr_pulse = wr_pulse_q;

  assign s.s_awready = aw_ready;
  assign s.s_arready = ar_ready;
  assign s.s_wready  = w_ready;
  assign s.s_bvalid  = b_valid;
  assign s.s_bid     = aw_id_q;
  assign s.s_bresp   = w_err_q ? RESP_SLVERR : RESP_OKAY;
  assign s.s_rvalid  = r_valid;
  assign s.s_rid     = ar_id_q;
  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = rresp_q;
  assign s.s_rlast   = rlast_q;

endmodule

// File: tb/tb_h2f_axi_regbank.sv
// Self-checking bench for h2f_axi_regbank: scoreboard queues for B and R,
// a vector table of single-beat accesses, and hand-written burst sequences.
module tb_h2f_axi_regbank;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 30;
  localparam int ID_W   = 12;
  localparam logic [1:0] OK = 2'b00, SLV = 2'b10;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  h2f_axi_regbank_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();
  logic [NREGS*32-1:0] reg_q;
  logic [NREGS-1:0]    reg_wr_pulse;

  h2f_axi_regbank #(.NREGS(NREGS), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .bus_clock_clk     (clk),
    .bus_reset_reset_n (rst_n),
    .s                 (bus),
    .reg_q             (reg_q),
    .reg_wr_pulse      (reg_wr_pulse)
  );

  typedef struct {logic [ID_W-1:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct {logic [ID_W-1:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;
  typedef struct {logic [ADDR_W-1:0] addr; logic [3:0] strb; logic [31:0] data;
                  logic [1:0] resp; logic [31:0] rd;} vec_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];
  logic [31:0] model [NREGS];
  logic [31:0] wdat [16];
  vec_t vecs [6];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    b_q.push_back(e);
  endtask

  task automatic push_r(input logic [ID_W-1:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  task automatic set_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                        input logic [3:0] len, input logic [1:0] burst);
    bus.s_awid = id; bus.s_awaddr = addr; bus.s_awlen = len; bus.s_awsize = 3'd2;
    bus.s_awburst = burst; bus.s_awvalid = 1'b1;
  endtask

  task automatic set_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                        input logic [3:0] len, input logic [1:0] burst);
    bus.s_arid = id; bus.s_araddr = addr; bus.s_arlen = len; bus.s_arsize = 3'd2;
    bus.s_arburst = burst; bus.s_arvalid = 1'b1;
  endtask

  task automatic wait_aw();
    int n = 0;
    logic hs = 1'b0;
    while (!hs && n < 50) begin @(negedge clk); hs = bus.s_awready; n++; end
    check("aw_handshake", hs, 1);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
  endtask

  task automatic wait_ar();
    int n = 0;
    logic hs = 1'b0;
    while (!hs && n < 50) begin @(negedge clk); hs = bus.s_arready; n++; end
    check("ar_handshake", hs, 1);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
  endtask

  // last_at selects which beat carries wlast (-1: none)
  task automatic w_phase(input logic [ID_W-1:0] wid, input int nbeats, input logic [3:0] strb, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      logic hs = 1'b0;
      bus.s_wid = wid; bus.s_wdata = wdat[i]; bus.s_wstrb = strb;
      bus.s_wlast = (i == last_at); bus.s_wvalid = 1'b1;
      while (!hs && n < 50) begin @(negedge clk); hs = bus.s_wready; n++; end
      check("w_handshake", hs, 1);
      check("no_early_bvalid", bus.s_bvalid, 0);
      @(posedge clk); #1;
    end
    bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    logic hs = 1'b0;
    b_exp_t e;
    while (!hs && n < 50) begin @(negedge clk); hs = bus.s_bvalid & bus.s_bready; n++; end
    check("b_handshake", hs, 1);
    if (b_q.size() == 0) begin
      check("b_unexpected", 1, 0);
    end else begin
      e = b_q.pop_front();
      check("bid", bus.s_bid, e.id);
      check("bresp", bus.s_bresp, e.resp);
    end
    @(posedge clk); #1;
  endtask

  // stall_at: beat index at which rready is held low for 5 cycles (-1: none)
  task automatic r_phase(input int nbeats, input int stall_at);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      logic hs = 1'b0;
      r_exp_t e;
      while (!hs && n < 50) begin @(negedge clk); hs = bus.s_rvalid; n++; end
      check("r_valid_seen", hs, 1);
      check("r_one_beat_per_cycle", n, 1);
      if (i == stall_at) begin
        logic [31:0] sd;
        logic sl;
        sd = bus.s_rdata; sl = bus.s_rlast;
        bus.s_rready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_rvalid", bus.s_rvalid, 1);
          check("stall_rdata", bus.s_rdata, sd);
          check("stall_rlast", bus.s_rlast, sl);
        end
        bus.s_rready = 1'b1;
      end
      if (r_q.size() == 0) begin
        check("r_unexpected", 1, 0);
      end else begin
        e = r_q.pop_front();
        check("rid", bus.s_rid, e.id);
        check("rdata", bus.s_rdata, e.data);
        check("rresp", bus.s_rresp, e.resp);
        check("rlast", bus.s_rlast, e.last);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < NREGS; k++) check($sformatf("reg_q[%0d]", k), reg_q[32*k +: 32], model[k]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_awready"}, bus.s_awready, 0);
    check({tag, "_arready"}, bus.s_arready, 0);
    check({tag, "_wready"},  bus.s_wready, 0);
    check({tag, "_bvalid"},  bus.s_bvalid, 0);
    check({tag, "_rvalid"},  bus.s_rvalid, 0);
    check({tag, "_bid_bresp"}, {bus.s_bid, bus.s_bresp}, 0);
    check({tag, "_rdata"},   {bus.s_rid, bus.s_rdata, bus.s_rresp, bus.s_rlast}, 0);
    check({tag, "_reg_q"},   (reg_q == '0), 1);
    check({tag, "_pulse"},   reg_wr_pulse, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0; bus.s_awburst = '0;
    bus.s_awlock = '0; bus.s_awcache = '0; bus.s_awprot = '0; bus.s_awvalid = 1'b0;
    bus.s_wid = '0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 1'b0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b1;
    bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0; bus.s_arburst = '0;
    bus.s_arlock = '0; bus.s_arcache = '0; bus.s_arprot = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b1;
    for (int k = 0; k < NREGS; k++) model[k] = '0;

    vecs[0] = '{addr: 30'h14,   strb: 4'h2, data: 32'hAABBCCDD, resp: OK,  rd: 32'h0000CC00};
    vecs[1] = '{addr: 30'h40,   strb: 4'hF, data: 32'h12345678, resp: SLV, rd: 32'h0};
    vecs[2] = '{addr: 30'h10,   strb: 4'h9, data: 32'h11223344, resp: OK,  rd: 32'h11000044};
    vecs[3] = '{addr: 30'h3C,   strb: 4'hF, data: 32'hCAFEF00D, resp: OK,  rd: 32'hCAFEF00D};
    vecs[4] = '{addr: 30'h1C,   strb: 4'hC, data: 32'h12345678, resp: OK,  rd: 32'h12340000};
    vecs[5] = '{addr: 30'h1000, strb: 4'hF, data: 32'hFFFFFFFF, resp: SLV, rd: 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // simultaneous AW and AR after reset: write first
    set_aw(12'h011, 30'h0C, 4'd0, INCR);
    set_ar(12'h022, 30'h0C, 4'd0, INCR);
    @(negedge clk);
    check("pair1_awready", bus.s_awready, 1);
    check("pair1_arready", bus.s_arready, 0);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    wdat[0] = 32'h0000_0033;
    push_b(12'h011, OK);
    w_phase(12'h011, 1, 4'hF, 0);
    wait_b();
    model[3] = 32'h0000_0033;
    push_r(12'h022, 32'h0000_0033, OK, 1'b1);
    wait_ar();
    r_phase(1, -1);

    // next contested pair: read first
    set_aw(12'h033, 30'h0C, 4'd0, INCR);
    set_ar(12'h044, 30'h0C, 4'd0, INCR);
    @(negedge clk);
    check("pair2_arready", bus.s_arready, 1);
    check("pair2_awready", bus.s_awready, 0);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    push_r(12'h044, 32'h0000_0033, OK, 1'b1);
    r_phase(1, -1);
    wait_aw();
    wdat[0] = 32'h0;
    push_b(12'h033, OK);
    w_phase(12'h033, 1, 4'hF, 0);
    wait_b();
    model[3] = 32'h0;

    // single write then read
    set_aw(12'h123, 30'h08, 4'd0, INCR);
    wait_aw();
    wdat[0] = 32'hDEADBEEF;
    push_b(12'h123, OK);
    w_phase(12'h123, 1, 4'hF, 0);
    check("single_reg2", reg_q[95:64], 32'hDEADBEEF);
    check("single_pulse", reg_wr_pulse, 16'h0004);
    check("bvalid_next_cycle", bus.s_bvalid, 1);
    wait_b();
    check("single_pulse_gone", reg_wr_pulse, 16'h0000);
    model[2] = 32'hDEADBEEF;
    push_r(12'h0AB, 32'hDEADBEEF, OK, 1'b1);
    set_ar(12'h0AB, 30'h08, 4'd0, INCR);
    wait_ar();
    check("rvalid_after_ar", bus.s_rvalid, 1);
    r_phase(1, -1);

    // INCR write len=3 at 0
    set_aw(12'h005, 30'h00, 4'd3, INCR);
    wait_aw();
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    push_b(12'h005, OK);
    w_phase(12'h005, 4, 4'hF, 3);
    wait_b();
    for (int i = 0; i < 4; i++) model[i] = 32'(i + 1);
    check_regs();

    // WRAP read len=3 at 0x08 -> 3,4,1,2
    push_r(12'h006, 32'd3, OK, 1'b0);
    push_r(12'h006, 32'd4, OK, 1'b0);
    push_r(12'h006, 32'd1, OK, 1'b0);
    push_r(12'h006, 32'd2, OK, 1'b1);
    set_ar(12'h006, 30'h08, 4'd3, WRAP);
    wait_ar();
    r_phase(4, -1);

    // FIXED read len=2 at reg 1, with rready stalled mid-burst on a following INCR read
    push_r(12'h00F, 32'd2, OK, 1'b0);
    push_r(12'h00F, 32'd2, OK, 1'b0);
    push_r(12'h00F, 32'd2, OK, 1'b1);
    set_ar(12'h00F, 30'h04, 4'd2, FIXED);
    wait_ar();
    r_phase(3, -1);
    for (int i = 0; i < 4; i++) push_r(12'h007, 32'(i + 1), OK, (i == 3));
    set_ar(12'h007, 30'h00, 4'd3, INCR);
    wait_ar();
    r_phase(4, 1);

    // single-beat vector table
    for (int i = 0; i < 6; i++) begin
      logic [ID_W-1:0] id;
      id = ID_W'(12'h300 + i);
      set_aw(id, vecs[i].addr, 4'd0, INCR);
      wait_aw();
      wdat[0] = vecs[i].data;
      push_b(id, vecs[i].resp);
      w_phase(id, 1, vecs[i].strb, 0);
      wait_b();
      if (vecs[i].resp == OK) model[vecs[i].addr[5:2]] = vecs[i].rd;
      push_r(id, vecs[i].rd, vecs[i].resp, 1'b1);
      set_ar(id, vecs[i].addr, 4'd0, INCR);
      wait_ar();
      r_phase(1, -1);
    end
    check_regs();

    // INCR read crossing the top of the bank
    push_r(12'h010, 32'hCAFEF00D, OK, 1'b0);
    push_r(12'h010, 32'h0, SLV, 1'b1);
    set_ar(12'h010, 30'h3C, 4'd1, INCR);
    wait_ar();
    r_phase(2, -1);

    // bready held low: bvalid/bid/bresp stable, no new AW accepted
    bus.s_bready = 1'b0;
    set_aw(12'h055, 30'h18, 4'd0, INCR);
    wait_aw();
    wdat[0] = 32'h66;
    push_b(12'h055, OK);
    w_phase(12'h055, 1, 4'hF, 0);
    model[6] = 32'h66;
    set_aw(12'h056, 30'h18, 4'd0, INCR);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bhold_bvalid", bus.s_bvalid, 1);
      check("bhold_bid_bresp", {bus.s_bid, bus.s_bresp}, {12'h055, OK});
      check("bhold_awready", bus.s_awready, 0);
    end
    @(posedge clk); #1;
    bus.s_bready = 1'b1;
    wait_b();
    wait_aw();
    wdat[0] = 32'h67;
    push_b(12'h056, OK);
    w_phase(12'h056, 1, 4'hF, 0);
    wait_b();
    model[6] = 32'h67;
    check_regs();

    // mismatched wid -> SLVERR (data equals current contents of reg 0)
    set_aw(12'h100, 30'h00, 4'd0, INCR);
    wait_aw();
    wdat[0] = model[0];
    push_b(12'h100, SLV);
    w_phase(12'h101, 1, 4'hF, 0);
    wait_b();

    // reserved burst type -> SLVERR, no register changes
    set_aw(12'h150, 30'h2C, 4'd0, 2'b11);
    wait_aw();
    wdat[0] = 32'h99;
    push_b(12'h150, SLV);
    w_phase(12'h150, 1, 4'hF, 0);
    wait_b();
    check_regs();

    // early wlast: burst still runs 4 beats, then SLVERR
    set_aw(12'h200, 30'h20, 4'd3, INCR);
    wait_aw();
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 5);
    push_b(12'h200, SLV);
    w_phase(12'h200, 4, 4'hF, 1);
    wait_b();

    // reset during beat 2 of a len=7 write
    set_aw(12'h077, 30'h00, 4'd7, INCR);
    wait_aw();
    for (int i = 0; i < 3; i++) wdat[i] = 32'hA0 + 32'(i);
    w_phase(12'h077, 2, 4'hF, -1);
    bus.s_wid = 12'h077; bus.s_wdata = wdat[2]; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    bus.s_wvalid = 1'b0;
    b_q.delete();
    r_q.delete();
    for (int k = 0; k < NREGS; k++) model[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_aw(12'h009, 30'h04, 4'd0, INCR);
    wait_aw();
    wdat[0] = 32'h0000BEEF;
    push_b(12'h009, OK);
    w_phase(12'h009, 1, 4'hF, 0);
    wait_b();
    model[1] = 32'h0000BEEF;
    push_r(12'h00A, 32'h0000BEEF, OK, 1'b1);
    set_ar(12'h00A, 30'h04, 4'd0, INCR);
    wait_ar();
    r_phase(1, -1);
    check_regs();
    check("b_queue_empty", b_q.size(), 0);
    check("r_queue_empty", r_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
